// File: rtl/connect_count_accumulator_pkg.sv
// Shared constants and the completed-top result record for the connected-count accumulator.
package connect_count_accumulator_pkg;

  localparam int COUNT_WIDTH             = 6;
  localparam int DEFAULT_SUM_WIDTH       = 64;
  localparam int DEFAULT_BOT_COUNT_WIDTH = 16;

  typedef struct packed {
    logic [DEFAULT_SUM_WIDTH-1:0]       sum;
    logic [DEFAULT_BOT_COUNT_WIDTH-1:0] bot_count;
    logic                               overflow;
    logic                               ecc;
  } result_t;

  function automatic int result_bits(input int sum_w, input int cnt_w);
    return sum_w + cnt_w + 2;
  endfunction

endpackage

// File: rtl/connect_count_accumulator_if.sv
// Result handshake bus between the accumulator's result FIFO and its consumer.
interface connect_count_accumulator_if #(
  parameter int SUM_WIDTH       = 64,
  parameter int BOT_COUNT_WIDTH = 16
);

  logic                       sumValid;
  logic                       sumReady;
  logic [SUM_WIDTH-1:0]       sumOut;
  logic [BOT_COUNT_WIDTH-1:0] botCountOut;
  logic                       sumOverflow;
  logic                       eccErrorOut;

  modport master (
    output sumValid, sumOut, botCountOut, sumOverflow, eccErrorOut,
    input  sumReady
  );

  modport slave (
    input  sumValid, sumOut, botCountOut, sumOverflow, eccErrorOut,
    output sumReady
  );

endinterface

// File: rtl/connect_count_accumulator_result_fifo.sv
// First-word-fall-through result FIFO with registered almost-full and a drop pulse on overflow.
module result_fifo #(
  parameter int WIDTH              = 8,
  parameter int DEPTH_LOG2         = 4,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             almost_full,
  output logic             drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LEVEL   = (DEPTH_LOG2+1)'(DEPTH - ALMOST_FULL_MARGIN);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  almost_full_q, almost_full_d;
  logic                  empty, full, push_ok, pop_ok;

  // A pop frees the slot at the same edge, so a full FIFO can still accept a push alongside it.
  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == FULL_COUNT);
    pop_ok        = pop && !empty;
    push_ok       = push && (!full || pop_ok);
    drop          = push && full && !pop_ok;
    mem_d         = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d      = wr_ptr_q + DEPTH_LOG2'(push_ok);
    rd_ptr_d      = rd_ptr_q + DEPTH_LOG2'(pop_ok);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    almost_full_d = (count_d >= AF_LEVEL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign head_data   = mem_q[rd_ptr_q];
  assign head_valid  = !empty;
  assign almost_full = almost_full_q;

endmodule

// File: rtl/connect_count_accumulator.sv
// Accumulates sum(2^connectCount) and valid-bot counts per top, queueing finished tops for a consumer.
module connect_count_accumulator
  import connect_count_accumulator_pkg::*;
#(
  parameter int SUM_WIDTH          = DEFAULT_SUM_WIDTH,
  parameter int BOT_COUNT_WIDTH    = DEFAULT_BOT_COUNT_WIDTH,
  parameter int FIFO_DEPTH_LOG2    = 4,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   resultValid,
  input  logic [COUNT_WIDTH-1:0] connectCount,
  input  logic                   lastBotOfTop,
  input  logic                   eccStatusIn,
  connect_count_accumulator_if.master res,
  output logic                   fifoAlmostFull,
  output logic                   droppedResult
);

  localparam int RES_W = result_bits(SUM_WIDTH, BOT_COUNT_WIDTH);
  localparam logic [SUM_WIDTH-1:0] TERM_ONE = {{(SUM_WIDTH-1){1'b0}}, 1'b1};

  logic [SUM_WIDTH-1:0]       term_q, term_d;
  logic                       term_ovf_q, term_ovf_d;
  logic                       bot_inc_q, bot_inc_d;
  logic                       last_q, last_d;
  logic                       ecc_q, ecc_d;
  logic [SUM_WIDTH-1:0]       acc_sum_q, acc_sum_d;
  logic [BOT_COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic                       acc_ovf_q, acc_ovf_d;
  logic                       acc_ecc_q, acc_ecc_d;
  logic                       push_valid_q, push_valid_d;
  logic [RES_W-1:0]           push_data_q, push_data_d;
  logic                       dropped_q, dropped_d;
  logic [SUM_WIDTH-1:0]       sum_next;
  logic [BOT_COUNT_WIDTH-1:0] cnt_next;
  logic                       carry, ovf_next, ecc_next;
  logic [RES_W-1:0]           head_data;
  logic                       fifo_drop;

  // Counts at or beyond the sum width shift to zero, so they are flagged as overflow instead.
  always_comb begin
    term_d     = resultValid ? (TERM_ONE << connectCount) : '0;
    term_ovf_d = resultValid && (int'(connectCount) >= SUM_WIDTH);
    bot_inc_d  = resultValid;
    last_d     = lastBotOfTop;
    ecc_d      = eccStatusIn;
  end

  // The closing slot's contribution is folded in before the push; the next slot starts from zero.
  always_comb begin
    {carry, sum_next} = {1'b0, acc_sum_q} + {1'b0, term_q};
    cnt_next     = acc_cnt_q + {{(BOT_COUNT_WIDTH-1){1'b0}}, bot_inc_q};
    ovf_next     = acc_ovf_q | carry | term_ovf_q | (bot_inc_q && (acc_cnt_q == '1));
    ecc_next     = acc_ecc_q | ecc_q;
    push_valid_d = last_q;
    push_data_d  = {sum_next, cnt_next, ovf_next, ecc_next};
    acc_sum_d    = last_q ? '0   : sum_next;
    acc_cnt_d    = last_q ? '0   : cnt_next;
    acc_ovf_d    = last_q ? 1'b0 : ovf_next;
    acc_ecc_d    = last_q ? 1'b0 : ecc_next;
    dropped_d    = dropped_q | fifo_drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      term_q       <= '0;
      term_ovf_q   <= 1'b0;
      bot_inc_q    <= 1'b0;
      last_q       <= 1'b0;
      ecc_q        <= 1'b0;
      acc_sum_q    <= '0;
      acc_cnt_q    <= '0;
      acc_ovf_q    <= 1'b0;
      acc_ecc_q    <= 1'b0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      dropped_q    <= 1'b0;
    end else begin
      term_q       <= term_d;
      term_ovf_q   <= term_ovf_d;
      bot_inc_q    <= bot_inc_d;
      last_q       <= last_d;
      ecc_q        <= ecc_d;
      acc_sum_q    <= acc_sum_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_ovf_q    <= acc_ovf_d;
      acc_ecc_q    <= acc_ecc_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      dropped_q    <= dropped_d;
    end
  end

  result_fifo #(
    .WIDTH             (RES_W),
    .DEPTH_LOG2        (FIFO_DEPTH_LOG2),
    .ALMOST_FULL_MARGIN(ALMOST_FULL_MARGIN)
  ) u_result_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_valid_q),
    .push_data  (push_data_q),
    .pop        (res.sumReady),
    .head_data  (head_data),
    .head_valid (res.sumValid),
    .almost_full(fifoAlmostFull),
    .drop       (fifo_drop)
  );

  assign {res.sumOut, res.botCountOut, res.sumOverflow, res.eccErrorOut} = head_data;
  assign droppedResult = dropped_q;

endmodule

// File: tb/tb_connect_count_accumulator.sv
// Scoreboard bench: 64-bit and 8-bit builds share one stimulus stream and an exact-arithmetic model.
module tb_connect_count_accumulator;
  import connect_count_accumulator_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       resultValid = 1'b0;
  logic [5:0] connectCount = '0;
  logic       lastBotOfTop = 1'b0;
  logic       eccStatusIn = 1'b0;
  logic       readyTb = 1'b0;
  logic       almostFull64, almostFull8, dropped64, dropped8;

  int compared = 0;
  int mismatched = 0;

  logic [127:0] exactSum = '0;
  int           validBots = 0;
  bit           eccAny = 1'b0;
  bit           dropNext = 1'b0;
  result_t      expQ64[$];
  result_t      expQ8[$];

  connect_count_accumulator_if #(.SUM_WIDTH(64), .BOT_COUNT_WIDTH(16)) if64 ();
  connect_count_accumulator_if #(.SUM_WIDTH(8),  .BOT_COUNT_WIDTH(16)) if8 ();

  assign if64.sumReady = readyTb;
  assign if8.sumReady  = readyTb;

  connect_count_accumulator #(.SUM_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .resultValid(resultValid), .connectCount(connectCount),
    .lastBotOfTop(lastBotOfTop), .eccStatusIn(eccStatusIn), .res(if64),
    .fifoAlmostFull(almostFull64), .droppedResult(dropped64)
  );

  connect_count_accumulator #(.SUM_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .resultValid(resultValid), .connectCount(connectCount),
    .lastBotOfTop(lastBotOfTop), .eccStatusIn(eccStatusIn), .res(if8),
    .fifoAlmostFull(almostFull8), .droppedResult(dropped8)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Exact (unbounded) sum of the current top reduced to the build's width.
  function automatic result_t modelResult(input int w);
    logic [127:0] mask;
    result_t r;
    mask        = (128'(1) << w) - 128'(1);
    r.sum       = 64'(exactSum & mask);
    r.bot_count = 16'(validBots);
    r.overflow  = (exactSum > mask) || (validBots > 65535);
    r.ecc       = eccAny;
    return r;
  endfunction

  function automatic void clearModel();
    exactSum  = '0;
    validBots = 0;
    eccAny    = 1'b0;
  endfunction

  function automatic void checkOutput(input string name, input result_t act, input result_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got sum=%h cnt=%0d ovf=%b ecc=%b, expected sum=%h cnt=%0d ovf=%b ecc=%b",
               name, act.sum, act.bot_count, act.overflow, act.ecc,
               exp.sum, exp.bot_count, exp.overflow, exp.ecc);
    end
  endfunction

  function automatic void checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  task automatic applyStimulus(input bit v, input int c, input bit l, input bit e);
    @(posedge clk);
    #1;
    resultValid  = v;
    connectCount = 6'(c);
    lastBotOfTop = l;
    eccStatusIn  = e;
    if (v) begin
      exactSum  = exactSum + (128'(1) << c);
      validBots = validBots + 1;
    end
    if (e) eccAny = 1'b1;
    if (l) begin
      if (!dropNext) begin
        expQ64.push_back(modelResult(64));
        expQ8.push_back(modelResult(8));
      end
      clearModel();
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    resultValid = 1'b0; lastBotOfTop = 1'b0; eccStatusIn = 1'b0; connectCount = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clearModel();
  endtask

  task automatic waitDrained(input string name);
    bit done;
    done = 1'b0;
    readyTb = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      done = (expQ64.size() == 0) && (expQ8.size() == 0) && !if64.sumValid && !if8.sumValid;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL %s: drain timeout, pending64=%0d pending8=%0d", name, expQ64.size(), expQ8.size());
    end
  endtask

  // Monitor: every accepted head is popped from the scoreboard and compared.
  always @(negedge clk) begin
    result_t act;
    if (rst && if64.sumValid && if64.sumReady) begin
      act = '{sum: if64.sumOut, bot_count: if64.botCountOut, overflow: if64.sumOverflow, ecc: if64.eccErrorOut};
      if (expQ64.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL w64 unexpected: got sum=%h, expected no result", if64.sumOut);
      end else checkOutput("w64 result", act, expQ64.pop_front());
    end
    if (rst && if8.sumValid && if8.sumReady) begin
      act = '{sum: {56'b0, if8.sumOut}, bot_count: if8.botCountOut, overflow: if8.sumOverflow, ecc: if8.eccErrorOut};
      if (expQ8.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL w8 unexpected: got sum=%h, expected no result", if8.sumOut);
      end else checkOutput("w8 result", act, expQ8.pop_front());
    end
  end

  initial begin
    doReset();
    checkVal("reset sumValid",    64'(if64.sumValid),    64'd0);
    checkVal("reset sumOut",      if64.sumOut,           64'd0);
    checkVal("reset botCount",    64'(if64.botCountOut), 64'd0);
    checkVal("reset overflow",    64'(if64.sumOverflow), 64'd0);
    checkVal("reset ecc",         64'(if64.eccErrorOut), 64'd0);
    checkVal("reset almostFull",  64'(almostFull64),     64'd0);
    checkVal("reset dropped",     64'(dropped64),        64'd0);
    checkVal("reset w8 sumValid", 64'(if8.sumValid),     64'd0);

    $display("[TB] first top and latency");
    readyTb = 1'b0;
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    idleCycles(2);
    checkVal("latency edge2 sumValid", 64'(if64.sumValid), 64'd0);
    idleCycles(1);
    checkVal("latency edge3 sumValid", 64'(if64.sumValid), 64'd1);
    waitDrained("first top");

    $display("[TB] back-to-back single-slot tops");
    applyStimulus(1'b1, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 3, 1'b1, 1'b0);
    applyStimulus(1'b1, 4, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idleCycles(1);
      checkVal($sformatf("b2b valid %0d", k), 64'(if64.sumValid), 64'd1);
    end
    idleCycles(1);
    checkVal("b2b valid after", 64'(if64.sumValid), 64'd0);
    waitDrained("back-to-back");

    $display("[TB] empty top, invalid slot, narrow-width overflow");
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 7, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0);
    waitDrained("directed tops");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      readyTb = ($urandom_range(0, 3) != 0);
      if (almostFull64) applyStimulus(1'b0, 0, 1'b0, 1'b0);
      else applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
                         ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    waitDrained("random");
    checkVal("random dropped", 64'(dropped64), 64'd0);

    $display("[TB] fill, almost-full, drop");
    readyTb = 1'b0;
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, int'($urandom_range(0, 63)), 1'b1, 1'b0);
    idleCycles(4);
    checkVal("almostFull at 11", 64'(almostFull64), 64'd0);
    applyStimulus(1'b1, int'($urandom_range(0, 63)), 1'b1, 1'b0);
    idleCycles(4);
    checkVal("almostFull at 12", 64'(almostFull64), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, int'($urandom_range(0, 63)), 1'b1, 1'b0);
    idleCycles(4);
    checkVal("dropped before full push", 64'(dropped64), 64'd0);
    dropNext = 1'b1;
    applyStimulus(1'b1, 9, 1'b1, 1'b1);
    dropNext = 1'b0;
    idleCycles(4);
    checkVal("dropped w64", 64'(dropped64), 64'd1);
    checkVal("dropped w8",  64'(dropped8),  64'd1);

    applyStimulus(1'b1, 6, 1'b1, 1'b0);
    idleCycles(2);
    readyTb = 1'b1;
    idleCycles(1);
    readyTb = 1'b0;
    idleCycles(3);
    checkVal("full push+pop keeps full", 64'(almostFull64), 64'd1);
    waitDrained("fill drain");
    checkVal("almostFull after drain", 64'(almostFull64), 64'd0);

    $display("[TB] reset mid-top");
    applyStimulus(1'b1, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    doReset();
    checkVal("post-reset dropped", 64'(dropped64), 64'd0);
    checkVal("post-reset sumValid", 64'(if64.sumValid), 64'd0);
    applyStimulus(1'b1, 3, 1'b0, 1'b0);
    applyStimulus(1'b1, 3, 1'b1, 1'b0);
    waitDrained("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
